// File: rtl/sudoku_cell_store_if.sv
// Write-request / response channel of the Sudoku cell store.
// The master (keypad/cursor side) drives requests; the slave (cell store)
// drives ready and the one-cycle response pulse.
interface sudoku_cell_store_if #(
    parameter int VW = 4,
    parameter int IW = 4
);
    logic          wr_valid;
    logic          wr_ready;
    logic [IW-1:0] wr_row;
    logic [IW-1:0] wr_col;
    logic [VW-1:0] wr_value;
    logic          wr_given;
    logic          resp_valid;
    logic [1:0]    resp_code;

    modport master (
        output wr_valid, wr_row, wr_col, wr_value, wr_given,
        input  wr_ready, resp_valid, resp_code
    );

    modport slave (
        input  wr_valid, wr_row, wr_col, wr_value, wr_given,
        output wr_ready, resp_valid, resp_code
    );
endinterface

// File: rtl/sudoku_cell_store.sv
// Guess/status grid for a BOX^2 x BOX^2 Sudoku. One write at a time is
// accepted, checked against its row, column and box over N cycles (one index
// k per cycle), then committed or rejected with a response code. Every
// request takes exactly N+1 cycles from acceptance to the response pulse.
module sudoku_cell_store #(
    parameter int BOX    = 3,
    parameter int STRICT = 1,
    parameter int VW     = $clog2(BOX*BOX+1),
    parameter int IW     = $clog2(BOX*BOX)
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    sudoku_cell_store_if.slave                     bus,
    input  logic                                   clear,
    input  logic [IW-1:0]                          rd_row,
    input  logic [IW-1:0]                          rd_col,
    output logic [VW-1:0]                          rd_value,
    output logic [1:0]                             rd_status,
    output logic [$clog2(BOX*BOX*BOX*BOX+1)-1:0]   filled_count
);
    localparam int N     = BOX * BOX;
    localparam int CELLS = N * N;
    localparam int XW    = $clog2(CELLS);
    localparam int CW    = $clog2(CELLS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Flattened cell index, row-major.
    function automatic logic [XW-1:0] cell_idx(input logic [IW-1:0] r, input logic [IW-1:0] c);
        return XW'(32'(r) * 32'(N) + 32'(c));
    endfunction

    function automatic logic in_grid(input logic [IW-1:0] r, input logic [IW-1:0] c);
        return (32'(r) < 32'(N)) && (32'(c) < 32'(N));
    endfunction

    logic [VW-1:0] cell_value  [CELLS];
    logic [1:0]    cell_status [CELLS];

    state_t        state;
    logic [IW-1:0] k_r;
    logic [IW-1:0] row_r;
    logic [IW-1:0] col_r;
    logic [VW-1:0] value_r;
    logic          given_r;
    logic          range_r;
    logic          conflict_r;
    logic          resp_valid_r;
    logic [1:0]    resp_code_r;

    logic          accept_s;
    logic          clear_s;
    logic [IW-1:0] box_row_s;
    logic [IW-1:0] box_col_s;
    logic [XW-1:0] tgt_idx_s;
    logic [XW-1:0] row_idx_s;
    logic [XW-1:0] col_idx_s;
    logic [XW-1:0] box_idx_s;
    logic          hit_s;
    logic [1:0]    code_s;
    logic          write_s;
    logic [1:0]    new_status_s;
    logic          old_nz_s;
    logic          new_nz_s;
    logic [CW-1:0] given_count_s;

    assign bus.wr_ready   = (state == IDLE) && !clear;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_code  = resp_code_r;
    assign accept_s       = bus.wr_valid && bus.wr_ready;
    assign clear_s        = clear && (state == IDLE);

    // Scan addressing and duplicate detection for the current k, plus commit decision.
    always_comb begin
        box_row_s = IW'(32'(BOX) * (32'(row_r) / 32'(BOX)) + 32'(k_r) / 32'(BOX));
        box_col_s = IW'(32'(BOX) * (32'(col_r) / 32'(BOX)) + 32'(k_r) % 32'(BOX));
        tgt_idx_s = cell_idx(row_r, col_r);
        row_idx_s = cell_idx(row_r, k_r);
        col_idx_s = cell_idx(k_r, col_r);
        box_idx_s = cell_idx(box_row_s, box_col_s);
        // A zero value never matches, so empty cells and erase requests never conflict.
        hit_s = (value_r != {VW{1'b0}}) && !range_r &&
                (((row_idx_s != tgt_idx_s) && (cell_value[row_idx_s] == value_r)) ||
                 ((col_idx_s != tgt_idx_s) && (cell_value[col_idx_s] == value_r)) ||
                 ((box_idx_s != tgt_idx_s) && (cell_value[box_idx_s] == value_r)));
        if (range_r) begin
            code_s = 2'd2;
        end else if ((cell_status[tgt_idx_s] == 2'd1) && !given_r) begin
            code_s = 2'd1;
        end else if (conflict_r) begin
            code_s = 2'd3;
        end else begin
            code_s = 2'd0;
        end
        write_s      = (code_s == 2'd0) || ((code_s == 2'd3) && (STRICT == 0));
        new_status_s = (value_r == {VW{1'b0}}) ? 2'd0 : (given_r ? 2'd1 : 2'd2);
        old_nz_s     = !range_r && (cell_value[tgt_idx_s] != {VW{1'b0}});
        new_nz_s     = (value_r != {VW{1'b0}});
    end

    // Number of given cells: the filled count that survives a clear.
    always_comb begin
        given_count_s = {CW{1'b0}};
        for (int i = 0; i < CELLS; i++) begin
            if (cell_status[i] == 2'd1) begin
                given_count_s = given_count_s + CW'(1);
            end else begin
                given_count_s = given_count_s;
            end
        end
    end

    // Request FSM: accept, scan k = 0..N-1, then issue the response pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            k_r          <= {IW{1'b0}};
            row_r        <= {IW{1'b0}};
            col_r        <= {IW{1'b0}};
            value_r      <= {VW{1'b0}};
            given_r      <= 1'b0;
            range_r      <= 1'b0;
            conflict_r   <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_code_r  <= 2'd0;
        end else begin
            resp_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_s) begin
                        row_r      <= bus.wr_row;
                        col_r      <= bus.wr_col;
                        value_r    <= bus.wr_value;
                        given_r    <= bus.wr_given;
                        range_r    <= !in_grid(bus.wr_row, bus.wr_col) ||
                                      (32'(bus.wr_value) > 32'(N));
                        conflict_r <= 1'b0;
                        k_r        <= {IW{1'b0}};
                        state      <= CHECK;
                    end else begin
                        state <= IDLE;
                    end
                end
                CHECK: begin
                    conflict_r <= conflict_r | hit_s;
                    if (k_r == IW'(N - 1)) begin
                        state <= COMMIT;
                    end else begin
                        k_r <= k_r + IW'(1);
                    end
                end
                COMMIT: begin
                    resp_valid_r <= 1'b1;
                    resp_code_r  <= code_s;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Grid storage and filled count: clear of user cells, or commit of the pending write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CELLS; i++) begin
                cell_value[i]  <= {VW{1'b0}};
                cell_status[i] <= 2'd0;
            end
            filled_count <= {CW{1'b0}};
        end else if (clear_s) begin
            for (int i = 0; i < CELLS; i++) begin
                if (cell_status[i] == 2'd2) begin
                    cell_value[i]  <= {VW{1'b0}};
                    cell_status[i] <= 2'd0;
                end
            end
            filled_count <= given_count_s;
        end else if ((state == COMMIT) && write_s) begin
            cell_value[tgt_idx_s]  <= value_r;
            cell_status[tgt_idx_s] <= new_status_s;
            if (old_nz_s && !new_nz_s) begin
                filled_count <= filled_count - CW'(1);
            end else if (!old_nz_s && new_nz_s) begin
                filled_count <= filled_count + CW'(1);
            end
        end
    end

    // Registered read port; sees the grid as it was before any same-edge write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_value  <= {VW{1'b0}};
            rd_status <= 2'd0;
        end else if (in_grid(rd_row, rd_col)) begin
            rd_value  <= cell_value[cell_idx(rd_row, rd_col)];
            rd_status <= cell_status[cell_idx(rd_row, rd_col)];
        end else begin
            rd_value  <= {VW{1'b0}};
            rd_status <= 2'd0;
        end
    end
endmodule

// File: tb/tb_sudoku_cell_store.sv
// Directed bench for sudoku_cell_store (BOX=3). Instance a is STRICT=1 and is
// the main target; instance b is STRICT=0 and sees identical stimulus.
module tb_sudoku_cell_store;
    localparam int VW = 4;
    localparam int IW = 4;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear   = 1'b0;
    logic [3:0] rd_row  = 4'd0;
    logic [3:0] rd_col  = 4'd0;
    logic [3:0] rd_value_a, rd_value_b;
    logic [1:0] rd_status_a, rd_status_b;
    logic [6:0] filled_a, filled_b;

    sudoku_cell_store_if #(.VW(VW), .IW(IW)) ifa ();
    sudoku_cell_store_if #(.VW(VW), .IW(IW)) ifb ();

    assign ifb.wr_valid = ifa.wr_valid;
    assign ifb.wr_row   = ifa.wr_row;
    assign ifb.wr_col   = ifa.wr_col;
    assign ifb.wr_value = ifa.wr_value;
    assign ifb.wr_given = ifa.wr_given;

    sudoku_cell_store #(.BOX(3), .STRICT(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(ifa.slave), .clear(clear),
        .rd_row(rd_row), .rd_col(rd_col), .rd_value(rd_value_a),
        .rd_status(rd_status_a), .filled_count(filled_a)
    );

    sudoku_cell_store #(.BOX(3), .STRICT(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(ifb.slave), .clear(clear),
        .rd_row(rd_row), .rd_col(rd_col), .rd_value(rd_value_b),
        .rd_status(rd_status_b), .filled_count(filled_b)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int r; int c; int v; int g;
        int rr; int rc;
        int code; int old_v; int val; int st; int cnt;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one write, wait for the response; lat counts edges after acceptance.
    task automatic do_write(input int r, input int c, input int v, input int g,
                            input int rr, input int rc,
                            output int lat, output int code_a, output int code_b,
                            output int old_a, output int busy_ready);
        @(negedge clock);
        ifa.wr_valid = 1'b1;
        ifa.wr_row   = 4'(r);
        ifa.wr_col   = 4'(c);
        ifa.wr_value = 4'(v);
        ifa.wr_given = (g != 0);
        rd_row       = 4'(rr);
        rd_col       = 4'(rc);
        @(posedge clock);
        @(negedge clock);
        ifa.wr_valid = 1'b0;
        busy_ready   = int'(ifa.wr_ready);
        lat    = 99;
        code_a = 99;
        code_b = 99;
        old_a  = 99;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (ifa.resp_valid) begin
                lat    = n;
                code_a = int'(ifa.resp_code);
                code_b = ifb.resp_valid ? int'(ifb.resp_code) : 98;
                old_a  = int'(rd_value_a);
                break;
            end
        end
    endtask

    task automatic read_cell(input int r, input int c);
        @(negedge clock);
        rd_row = 4'(r);
        rd_col = 4'(c);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, ca, cb, old, rdy, seen;
        ifa.wr_valid = 1'b0;
        ifa.wr_row   = 4'd0;
        ifa.wr_col   = 4'd0;
        ifa.wr_value = 4'd0;
        ifa.wr_given = 1'b0;

        // r, c, v, g, read r, read c, code, old, value, status, filled
        tbl[0]  = '{1, 1, 1, 0, 1, 1, 0, 0, 1, 2, 1};
        tbl[1]  = '{4, 2, 6, 1, 4, 2, 0, 0, 6, 1, 2};
        tbl[2]  = '{4, 2, 3, 0, 4, 2, 1, 6, 6, 1, 2};
        tbl[3]  = '{0, 0, 5, 0, 0, 0, 0, 0, 5, 2, 3};
        tbl[4]  = '{0, 8, 5, 0, 0, 8, 3, 0, 0, 0, 3};
        tbl[5]  = '{3, 3, 7, 0, 3, 3, 0, 0, 7, 2, 4};
        tbl[6]  = '{5, 5, 7, 0, 5, 5, 3, 0, 0, 0, 4};
        tbl[7]  = '{8, 8, 10, 0, 8, 8, 2, 0, 0, 0, 4};
        tbl[8]  = '{9, 0, 1, 0, 0, 0, 2, 5, 5, 2, 4};
        tbl[9]  = '{8, 0, 5, 0, 8, 0, 3, 0, 0, 0, 4};
        tbl[10] = '{1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 3};
        tbl[11] = '{4, 2, 0, 1, 4, 2, 0, 6, 0, 0, 2};
        tbl[12] = '{4, 2, 9, 1, 4, 2, 0, 0, 9, 1, 3};
        tbl[13] = '{4, 2, 4, 1, 4, 2, 0, 9, 4, 1, 3};
        tbl[14] = '{0, 1, 5, 1, 0, 1, 3, 0, 0, 0, 3};
        tbl[15] = '{0, 0, 5, 0, 0, 0, 0, 5, 5, 2, 3};
        tbl[16] = '{8, 8, 9, 0, 8, 8, 0, 0, 9, 2, 4};
        tbl[17] = '{4, 2, 15, 0, 4, 2, 2, 4, 4, 1, 4};

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset_resp_valid", int'(ifa.resp_valid), 0);
        chk("reset_resp_code", int'(ifa.resp_code), 0);
        chk("reset_rd_value", int'(rd_value_a), 0);
        chk("reset_rd_status", int'(rd_status_a), 0);
        chk("reset_filled", int'(filled_a), 0);
        chk("reset_wr_ready", int'(ifa.wr_ready), 1);

        for (int i = 0; i < 18; i++) begin
            do_write(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].g, tbl[i].rr, tbl[i].rc,
                     lat, ca, cb, old, rdy);
            chk($sformatf("v%0d_latency", i), lat, 10);
            chk($sformatf("v%0d_busy_ready", i), rdy, 0);
            chk($sformatf("v%0d_code", i), ca, tbl[i].code);
            chk($sformatf("v%0d_old_value", i), old, tbl[i].old_v);
            @(negedge clock);
            chk($sformatf("v%0d_pulse_end", i), int'(ifa.resp_valid), 0);
            chk($sformatf("v%0d_value", i), int'(rd_value_a), tbl[i].val);
            chk($sformatf("v%0d_status", i), int'(rd_status_a), tbl[i].st);
            chk($sformatf("v%0d_filled", i), int'(filled_a), tbl[i].cnt);
        end

        // Clear: five cells, two of them given; a write offered with clear is dropped.
        do_reset();
        do_write(0, 0, 1, 1, 0, 0, lat, ca, cb, old, rdy);
        do_write(1, 3, 2, 1, 1, 3, lat, ca, cb, old, rdy);
        do_write(2, 6, 3, 0, 2, 6, lat, ca, cb, old, rdy);
        do_write(5, 5, 4, 0, 5, 5, lat, ca, cb, old, rdy);
        do_write(8, 8, 5, 0, 8, 8, lat, ca, cb, old, rdy);
        @(negedge clock);
        chk("pre_clear_filled", int'(filled_a), 5);
        clear        = 1'b1;
        ifa.wr_valid = 1'b1;
        ifa.wr_row   = 4'd7;
        ifa.wr_col   = 4'd7;
        ifa.wr_value = 4'd9;
        ifa.wr_given = 1'b0;
        #1;
        chk("clear_blocks_ready", int'(ifa.wr_ready), 0);
        @(negedge clock);
        clear        = 1'b0;
        ifa.wr_valid = 1'b0;
        chk("clear_filled", int'(filled_a), 2);
        seen = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clock);
            if (ifa.resp_valid) seen++;
        end
        chk("clear_write_dropped", seen, 0);
        read_cell(2, 6);
        chk("clear_user_value", int'(rd_value_a), 0);
        chk("clear_user_status", int'(rd_status_a), 0);
        read_cell(1, 3);
        chk("clear_given_value", int'(rd_value_a), 2);
        chk("clear_given_status", int'(rd_status_a), 1);
        read_cell(7, 7);
        chk("clear_no_write", int'(rd_value_a), 0);

        // Reset during CHECK cycle 4 aborts the request.
        do_reset();
        @(negedge clock);
        ifa.wr_valid = 1'b1;
        ifa.wr_row   = 4'd2;
        ifa.wr_col   = 4'd2;
        ifa.wr_value = 4'd8;
        ifa.wr_given = 1'b0;
        @(posedge clock);
        @(negedge clock);
        ifa.wr_valid = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clock);
            if (ifa.resp_valid) seen++;
        end
        chk("abort_no_resp", seen, 0);
        chk("abort_ready", int'(ifa.wr_ready), 1);
        read_cell(2, 2);
        chk("abort_cell", int'(rd_value_a), 0);
        chk("abort_filled", int'(filled_a), 0);

        // STRICT=0 commits the conflicting write; STRICT=1 does not.
        do_write(0, 0, 5, 0, 0, 0, lat, ca, cb, old, rdy);
        chk("s0_first_code", cb, 0);
        do_write(0, 8, 5, 0, 0, 8, lat, ca, cb, old, rdy);
        chk("s1_conflict_code", ca, 3);
        chk("s0_conflict_code", cb, 3);
        @(negedge clock);
        chk("s1_cell_empty", int'(rd_value_a), 0);
        chk("s0_cell_value", int'(rd_value_b), 5);
        chk("s0_cell_status", int'(rd_status_b), 2);
        chk("s0_filled", int'(filled_b), 2);
        chk("s1_filled", int'(filled_a), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
